fp_argmax_scanner: RTL and testbench

Sequencer that streams a vector of fp16 values through one shared fp16 greater-than comparator (`fp_comparator` instance) and reports the maximum value and its index. It sits between an activation/energy buffer and the selection logic of the annealing core, which uses it for winner-take-all and best-state tracking. One comparison per element per cycle; an optional build adds minimum tracking by time-sharing the same comparator.

---
 rtl/fp_argmax_scanner.sv | 141 ++++++++++++++
 tb/tb_fp_argmax_scanner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_argmax_scanner.sv
// Streams fp16 elements through one shared greater-than comparator and tracks the maximum value and its index.
// Build option FP_ARGMAX_MIN_EN adds minimum tracking by time-sharing the same comparator (MINCMP phase).
module fp_comparator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] num1,
  input  logic [DATA_WIDTH-1:0] num2,
  output logic                  gt
);
  // Sign-magnitude ordering: among negatives the smaller magnitude is larger; +0 beats -0.
  always_comb begin
    gt = 1'b0;
    if (num1[DATA_WIDTH-1] != num2[DATA_WIDTH-1])
      gt = ~num1[DATA_WIDTH-1];
    else if (!num1[DATA_WIDTH-1])
      gt = (num1[DATA_WIDTH-2:0] > num2[DATA_WIDTH-2:0]);
    else
      gt = (num1[DATA_WIDTH-2:0] < num2[DATA_WIDTH-2:0]);
  end
endmodule

module fp_argmax_scanner #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_WIDTH-1:0]  len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [IDX_WIDTH-1:0]  max_idx
`ifdef FP_ARGMAX_MIN_EN
  ,
  output logic [DATA_WIDTH-1:0] min_val,
  output logic [IDX_WIDTH-1:0]  min_idx
`endif
);
  // Handshake: an element transfers on a rising edge where s_valid && s_ready; s_ready is high only in SCAN.
`ifdef FP_ARGMAX_MIN_EN
  typedef enum logic [1:0] {IDLE, SCAN, MINCMP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
`endif

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  cnt, remaining;
  logic [DATA_WIDTH-1:0] cmp_a, cmp_b;
  logic                  cmp_gt;
  logic                  accept, last;

  assign s_ready = (state == SCAN);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign accept  = s_ready && s_valid;
  assign last    = (remaining == IDX_WIDTH'(1));

`ifdef FP_ARGMAX_MIN_EN
  logic [DATA_WIDTH-1:0] hold;
  assign cmp_a = (state == MINCMP) ? min_val : s_data;
  assign cmp_b = (state == MINCMP) ? hold    : max_val;
`else
  assign cmp_a = s_data;
  assign cmp_b = max_val;
`endif

  fp_comparator #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .num1 (cmp_a),
    .num2 (cmp_b),
    .gt   (cmp_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len == '0) ? DONE : SCAN;
`ifdef FP_ARGMAX_MIN_EN
      SCAN:   if (accept) state_nxt = MINCMP;
      MINCMP: state_nxt = (remaining == '0) ? DONE : SCAN;
`else
      SCAN:   if (accept && last) state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      remaining <= '0;
      max_val   <= '0;
      max_idx   <= '0;
`ifdef FP_ARGMAX_MIN_EN
      hold      <= '0;
      min_val   <= '0;
      min_idx   <= '0;
`endif
    end else if (state == IDLE && start) begin
      cnt       <= '0;
      remaining <= len;
      max_val   <= '0;
      max_idx   <= '0;
`ifdef FP_ARGMAX_MIN_EN
      hold      <= '0;
      min_val   <= '0;
      min_idx   <= '0;
`endif
    end else if (accept) begin
      cnt       <= cnt + IDX_WIDTH'(1);
      remaining <= remaining - IDX_WIDTH'(1);
      // Strict greater-than keeps the earliest index on ties.
      if (cnt == '0 || cmp_gt) begin
        max_val <= s_data;
        max_idx <= cnt;
      end
`ifdef FP_ARGMAX_MIN_EN
      hold <= s_data;
      if (cnt == '0) begin
        min_val <= s_data;
        min_idx <= '0;
      end
    end else if (state == MINCMP) begin
      // cnt already advanced past the held element, so its index is cnt-1.
      if (cmp_gt) begin
        min_val <= hold;
        min_idx <= cnt - IDX_WIDTH'(1);
      end
`endif
    end
  end
endmodule

// File: tb/tb_fp_argmax_scanner.sv
// Directed self-checking bench for fp_argmax_scanner; min checks are compiled in when FP_ARGMAX_MIN_EN is defined.
module tb_fp_argmax_scanner;
  localparam int DW = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] len = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          busy, done;
  logic [DW-1:0] max_val;
  logic [IW-1:0] max_idx;
`ifdef FP_ARGMAX_MIN_EN
  logic [DW-1:0] min_val;
  logic [IW-1:0] min_idx;
`endif

  int compared = 0;
  int mismatched = 0;

  fp_argmax_scanner #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .busy    (busy),
    .done    (done),
    .max_val (max_val),
    .max_idx (max_idx)
`ifdef FP_ARGMAX_MIN_EN
    ,
    .min_val (min_val),
    .min_idx (min_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_scan(input logic [IW-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  // Present one element and return just after the edge that accepted it.
  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("push_timeout", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  // Called right after the last accept: checks done latency, results, and single-cycle pulse.
  task automatic finish(input string tag, input logic [DW-1:0] emax, input logic [IW-1:0] eidx,
                        input logic [DW-1:0] emin, input logic [IW-1:0] emidx);
`ifdef FP_ARGMAX_MIN_EN
    check({tag, "_done_early"}, 32'(done), 32'd0);
    tick();
`endif
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_max_val"}, 32'(max_val), 32'(emax));
    check({tag, "_max_idx"}, 32'(max_idx), 32'(eidx));
`ifdef FP_ARGMAX_MIN_EN
    check({tag, "_min_val"}, 32'(min_val), 32'(emin));
    check({tag, "_min_idx"}, 32'(min_idx), 32'(emidx));
`else
    if (emin != emin || emidx != emidx) $display("unused");
`endif
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(max_val), 32'(emax));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_max_val", 32'(max_val), 32'd0);
    check("rst_max_idx", 32'(max_idx), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic max
    begin_scan(8'd4);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_s_ready", 32'(s_ready), 32'd1);
    push(16'h3C00);
    push(16'h4000);
    check("basic_running_max", 32'(max_val), 32'h4000);
    push(16'hC000);
    push(16'h3800);
    finish("basic", 16'h4000, 8'd1, 16'hC000, 8'd2);

    // Ties and signed zero
    begin_scan(8'd3);
    push(16'h8000);
    push(16'h0000);
    push(16'h0000);
    finish("tie", 16'h0000, 8'd1, 16'h8000, 8'd0);

    // All negative
    begin_scan(8'd3);
    push(16'hC400);
    push(16'hBC00);
    push(16'hC000);
    finish("neg", 16'hBC00, 8'd1, 16'hC400, 8'd0);

    // Zero length
    begin_scan(8'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_max_val", 32'(max_val), 32'd0);
    check("len0_max_idx", 32'(max_idx), 32'd0);
`ifdef FP_ARGMAX_MIN_EN
    check("len0_min_val", 32'(min_val), 32'd0);
`endif
    tick();
    check("len0_pulse", 32'(done), 32'd0);

    // Data offered while idle is not consumed
    s_valid = 1'b1;
    s_data  = 16'h7800;
    tick();
    tick();
    s_valid = 1'b0;
    check("idle_ignore_max", 32'(max_val), 32'd0);

    // Gaps in s_valid plus a start during the scan
    begin_scan(8'd3);
    push(16'h3C00);
    check("gap_first_max", 32'(max_val), 32'h3C00);
    start = 1'b1;
    len   = 8'd5;
    tick();
    start = 1'b0;
    tick();
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_stall_hold", 32'(max_val), 32'h3C00);
    push(16'h4400);
    tick();
    tick();
    push(16'h4200);
    finish("gap", 16'h4400, 8'd1, 16'h3C00, 8'd0);

    // Reset after 2 of 5 elements
    begin_scan(8'd5);
    push(16'h4000);
    push(16'h4200);
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_s_ready", 32'(s_ready), 32'd0);
    check("mrst_max_val", 32'(max_val), 32'd0);
    check("mrst_max_idx", 32'(max_idx), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("mrst_no_done", 32'(done), 32'd0);
      tick();
    end
    begin_scan(8'd2);
    push(16'h3800);
    push(16'hBC00);
    finish("post_rst", 16'h3800, 8'd0, 16'hBC00, 8'd1);

`ifdef FP_ARGMAX_MIN_EN
    // s_ready alternates with s_valid held high; exactly len elements consumed
    begin_scan(8'd2);
    s_valid = 1'b1;
    s_data  = 16'h4000;
    check("hs_r0", 32'(s_ready), 32'd1);
    tick();
    check("hs_r1", 32'(s_ready), 32'd0);
    s_data = 16'h4400;
    tick();
    check("hs_r2", 32'(s_ready), 32'd1);
    tick();
    check("hs_r3", 32'(s_ready), 32'd0);
    tick();
    check("hs_done", 32'(done), 32'd1);
    check("hs_max_idx", 32'(max_idx), 32'd1);
    check("hs_min_val", 32'(min_val), 32'h4000);
    tick();
    check("hs_idle_ready", 32'(s_ready), 32'd0);
    check("hs_max_val", 32'(max_val), 32'h4400);
    s_valid = 1'b0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    check("global_timeout", 32'd1, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
